alu_mul_sequencer: RTL and testbench

Multi-cycle sequencer for the multiply operation (ALU control code 4'b1111, R-type funct 24) in the single-cycle CPU. It takes the decoded ALU control code and both source operands, runs an iterative shift-add multiply over WIDTH cycles, and stalls the PC/register-write path until the product is ready. The product goes to the register write-back mux as a HI/LO pair.

---
 rtl/alu_mul_sequencer.sv | 119 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier: WIDTH+1 cycles from acceptance to done_o; stall_o holds the pipeline meanwhile.
// Define MUL_SIGNED_EN for a two's-complement multiply (magnitudes multiplied, sign fixed up at the end).
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] MUL_CODE = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 launch;
  logic [WIDTH-1:0]     op1, op2;
  logic [2*WIDTH-1:0]   acc_sum, final_prod;

  assign launch  = (state_q == IDLE) && start_i && (alu_ctrl_i == MUL_CODE);
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;

  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign op1        = src1_i[WIDTH-1] ? (~src1_i + 1'b1) : src1_i;
  assign op2        = src2_i[WIDTH-1] ? (~src2_i + 1'b1) : src2_i;
  assign final_prod = neg_q ? (~acc_sum + 1'b1) : acc_sum;
`else
  assign op1        = src1_i;
  assign op2        = src2_i;
  assign final_prod = acc_sum;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
`ifdef MUL_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (launch) begin
          mcand_d  = {{WIDTH{1'b0}}, op1};
          mplier_d = op2;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH);
          state_d  = RUN;
`ifdef MUL_SIGNED_EN
          neg_d    = src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
`endif
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        // Product registers load on the last iteration so they are valid throughout DONE.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          prod_d  = final_prod;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
`ifdef MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
`ifdef MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign hi_o    = prod_q[2*WIDTH-1:WIDTH];
  assign lo_o    = prod_q[WIDTH-1:0];
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign stall_o = launch || busy_o;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: cycle-exact timing plus products against an arithmetic model.
module tb_alu_mul_sequencer;
  localparam int W = 32;

  logic         clk;
  logic         rst_i;
  logic         start_i;
  logic [3:0]   alu_ctrl_i;
  logic [W-1:0] src1_i, src2_i;
  logic [W-1:0] hi_o, lo_o;
  logic         busy_o, done_o, stall_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .alu_ctrl_i(alu_ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .hi_o(hi_o), .lo_o(lo_o),
    .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    longint unsigned ua, ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
`endif
  endfunction

  // Launches a multiply in cycle 0 and checks every cycle through DONE (cycle W+1).
  // With hold=1, start_i stays high afterwards; operands switch to na/nb after acceptance.
  task automatic mul_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] exp,
                           input bit hold, input logic [W-1:0] na, input logic [W-1:0] nb,
                           input string tag);
    start_i = 1'b1; alu_ctrl_i = 4'b1111; src1_i = a; src2_i = b;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, stall_o} !== 3'b001) begin
      errors++;
      $display("FAIL %s launch: busy/done/stall=%b want 001", tag, {busy_o, done_o, stall_o});
    end
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
    src1_i = na; src2_i = nb;
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, stall_o} !== 3'b101 || hi_o !== exp_hi || lo_o !== exp_lo) begin
        errors++;
        $display("FAIL %s run cycle %0d: busy/done/stall=%b hi=%h lo=%h want 101 hi=%h lo=%h",
                 tag, c, {busy_o, done_o, stall_o}, hi_o, lo_o, exp_hi, exp_lo);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, stall_o} !== 3'b010) begin
      errors++;
      $display("FAIL %s done cycle: busy/done/stall=%b want 010", tag, {busy_o, done_o, stall_o});
    end
    checks++;
    if (hi_o !== exp[63:32] || lo_o !== exp[31:0]) begin
      errors++;
      $display("FAIL %s product: hi=%h lo=%h want hi=%h lo=%h", tag, hi_o, lo_o, exp[63:32], exp[31:0]);
    end
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; alu_ctrl_i = 4'b0000; src1_i = '0; src2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, stall_o} !== 3'b000 || hi_o !== '0 || lo_o !== '0) begin
      errors++;
      $display("FAIL reset: busy/done/stall=%b hi=%h lo=%h want 000 hi=0 lo=0",
               {busy_o, done_o, stall_o}, hi_o, lo_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_basic();
    mul_check(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, '0, '0, "mul_3x5");
  endtask

  task automatic test_max();
`ifdef MUL_SIGNED_EN
    mul_check(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, '0, '0, "mul_max");
`else
    mul_check(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, '0, '0, "mul_max");
`endif
  endtask

  task automatic test_neg_operand();
`ifdef MUL_SIGNED_EN
    mul_check(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, '0, '0, "mul_neg3x5");
`else
    mul_check(32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, 1'b0, '0, '0, "mul_neg3x5");
`endif
  endtask

  task automatic test_ignore_other_ctrl();
    logic [3:0] code;
    start_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      code = (c == 0) ? 4'b0010 : 4'($urandom_range(0, 14));
      alu_ctrl_i = code;
      src1_i = $urandom; src2_i = $urandom;
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, stall_o} !== 3'b000 || hi_o !== exp_hi || lo_o !== exp_lo) begin
        errors++;
        $display("FAIL ignore ctrl=%b: busy/done/stall=%b hi=%h lo=%h want 000 hi=%h lo=%h",
                 code, {busy_o, done_o, stall_o}, hi_o, lo_o, exp_hi, exp_lo);
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       begin a = 32'h8000_0000; b = 32'h8000_0000; end
        1:       begin a = '0;            b = $urandom;      end
        2:       begin a = $urandom;      b = 32'h8000_0000; end
        default: begin a = $urandom;      b = $urandom;      end
      endcase
      mul_check(a, b, ref_mul(a, b), 1'b0, '0, '0, "mul_random");
    end
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; alu_ctrl_i = 4'b1111; src1_i = $urandom; src2_i = $urandom;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, stall_o} !== 3'b000 || hi_o !== '0 || lo_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy/done/stall=%b hi=%h lo=%h want 000 hi=0 lo=0",
               {busy_o, done_o, stall_o}, hi_o, lo_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    exp_hi = '0; exp_lo = '0;
    mul_check(32'd7, 32'd6, 64'd42, 1'b0, '0, '0, "mul_after_reset");
  endtask

  task automatic test_back_to_back();
    mul_check(32'd2, 32'd2, 64'd4, 1'b1, 32'd9, 32'd9, "b2b_first");
    mul_check(32'd9, 32'd9, 64'd81, 1'b0, '0, '0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_neg_operand();
    test_ignore_other_ctrl();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
